output_port_arbiter: RTL

Round-robin, packet-locked arbiter for one router output port. It grants the output to one of five input ports, North/East/West/South/Local, whose LBDR request bit targets this port. It holds the grant from HEADER to TAIL and gates every flit on a downstream credit counter. One instance sits per output port, between the five LBDR/input-FIFO pairs and the crossbar select.

---
 rtl/noc_pkg.sv | 41 ++++
 rtl/output_port_arbiter_rr_picker.sv | 35 +++
 rtl/output_port_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// =============================================================================
// noc_pkg
// Shared router definitions: port indices, arbiter states, flit-id encodings.
// Revision: 1.0
// =============================================================================
package noc_pkg;

   localparam int NUM_PORTS = 5;
   localparam int PORT_N    = 0;
   localparam int PORT_E    = 1;
   localparam int PORT_W    = 2;
   localparam int PORT_S    = 3;
   localparam int PORT_L    = 4;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam logic [2:0] HEADER  = 3'b001;
   localparam logic [2:0] PAYLOAD = 3'b010;
   localparam logic [2:0] TAIL    = 3'b100;

   function automatic logic [2:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (oh[i]) begin
            idx = idx | 3'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [2:0] next_port(input logic [2:0] p);
      return (p >= 3'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_arbiter_rr_picker.sv
`default_nettype none
// =============================================================================
// rr_picker
// Combinational round-robin search: first eligible port at or after ptr_i.
// Revision: 1.0
// =============================================================================
module rr_picker
   import noc_pkg::*;
(
   input  logic [NUM_PORTS-1:0] elig_i,
   input  logic [2:0]           ptr_i,
   output logic [NUM_PORTS-1:0] winner_o,
   output logic                 any_o
);

   logic       found;
   logic [2:0] idx;

   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = 3'((int'(ptr_i) + k) % NUM_PORTS);
         if (!found && elig_i[idx]) begin
            winner_o[idx] = 1'b1;
            found         = 1'b1;
         end
      end
   end

   assign any_o = |elig_i;

endmodule
`default_nettype wire

// File: rtl/output_port_arbiter.sv
`default_nettype none
// =============================================================================
// output_port_arbiter
// Round-robin, packet-locked, credit-gated arbiter for one router output port.
// Optional stall watchdog: define ARB_WATCHDOG_EN.
// Revision: 1.0
// =============================================================================
module output_port_arbiter
   import noc_pkg::*;
#(
   parameter int BUF_DEPTH   = 4,
   parameter int WDOG_CYCLES = 64
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  req_in,
   input  logic [4:0]  valid_in,
   input  logic [14:0] flit_id_in,
   input  logic        credit_in,
   output logic [4:0]  grant,
   output logic [4:0]  rd_en,
   output logic [2:0]  sel,
   output logic        flit_valid_out,
   output logic        credit_err,
   output logic        wdog_err
);

   localparam int            CW          = $clog2(BUF_DEPTH + 1);
   localparam logic [CW-1:0] CREDITS_MAX = CW'(BUF_DEPTH);

   arb_state_t           state_q;
   logic [NUM_PORTS-1:0] grant_q;
   logic [2:0]           sel_q;
   logic [2:0]           rr_ptr_q;
   logic [CW-1:0]        credits_q;
   logic [CW-1:0]        credits_d;
   logic                 credit_err_q;
   logic                 credit_err_d;

   logic [NUM_PORTS-1:0] elig;
   logic [NUM_PORTS-1:0] winner;
   logic                 any_elig;
   logic [2:0]           win_id;
   logic                 has_credit;
   logic                 pop;
   logic                 tail_pop;
   logic                 wdog_fire;
   logic                 release_pkt;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_elig
      assign elig[i] = req_in[i] & valid_in[i] & (flit_id_in[3*i +: 3] == HEADER);
   end

   rr_picker u_picker (
      .elig_i   (elig),
      .ptr_i    (rr_ptr_q),
      .winner_o (winner),
      .any_o    (any_elig)
   );

   always_comb begin
      win_id = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_q[i]) begin
            win_id = win_id | flit_id_in[3*i +: 3];
         end
      end
   end

   assign has_credit = (credits_q != '0);

   always_comb begin
      rd_en = '0;
      if (state_q == LOCKED && has_credit) begin
         rd_en = grant_q & valid_in;
      end
   end

   assign pop            = |rd_en;
   assign flit_valid_out = pop;
   assign tail_pop       = pop & (win_id == TAIL);
   assign release_pkt    = tail_pop | wdog_fire;

   // A HEADER from the owner while locked is plain data; only TAIL or the watchdog unlock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         sel_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_elig && has_credit) begin
                  state_q <= LOCKED;
                  grant_q <= winner;
                  sel_q   <= onehot_to_idx(winner);
               end
            end
            LOCKED: begin
               if (release_pkt) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  sel_q    <= '0;
                  rr_ptr_q <= next_port(sel_q);
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               sel_q   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      if (pop && !credit_in) begin
         credits_d = credits_q - CW'(1);
      end else if (credit_in && !pop) begin
         if (credits_q == CREDITS_MAX) begin
            credit_err_d = 1'b1;
         end else begin
            credits_d = credits_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits_q    <= CREDITS_MAX;
         credit_err_q <= 1'b0;
      end else begin
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
      end
   end

`ifdef ARB_WATCHDOG_EN
   localparam int SW = $clog2(WDOG_CYCLES + 1);

   logic [SW-1:0] stall_q;
   logic          wdog_err_q;

   assign wdog_fire = (state_q == LOCKED) && !pop && (stall_q == SW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q    <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         if (state_q != LOCKED || pop || wdog_fire) begin
            stall_q <= '0;
         end else begin
            stall_q <= stall_q + SW'(1);
         end
         if (wdog_fire) begin
            wdog_err_q <= 1'b1;
         end
      end
   end

   assign wdog_err = wdog_err_q;
`else
   logic unused_wdog_cfg;

   assign wdog_fire       = 1'b0;
   assign wdog_err        = 1'b0;
   assign unused_wdog_cfg = |WDOG_CYCLES;
`endif

   assign grant      = grant_q;
   assign sel        = sel_q;
   assign credit_err = credit_err_q;

endmodule
`default_nettype wire
